// File: rtl/cyber_player_if.sv
// Bus between the cyber_player opponent and the top level: game enable and
// difficulty in, press pulse and LFSR observation out.
interface cyber_player_if #(
  parameter int LFSR_W = 10
);
  logic              en;
  logic [LFSR_W-1:0] level;
  logic              p;
  logic [LFSR_W-1:0] lfsr_q;

  modport master (output en, output level, input p, input lfsr_q);
  modport slave  (input en, input level, output p, output lfsr_q);
endinterface

// File: rtl/cyber_player.sv
// Computer-controlled tug-of-war opponent: pseudo-random one-cycle press pulses
// whose rate is set by comparing an LFSR against the difficulty level.
module cyber_player #(
  parameter int LFSR_W = 10,
  parameter int DIV_W  = 15
) (
  input  logic           clk,
  input  logic           rst,
  cyber_player_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e            state_q;
  logic              p_q;
  logic [DIV_W-1:0]  cnt_q;
  logic [DIV_W-1:0]  cnt_d;
  logic [LFSR_W-1:0] lfsr_st_q;
  logic [LFSR_W-1:0] lfsr_st_d;
  logic              tick_s;
  logic              fb_s;
  logic              hit_s;

  // XNOR feedback keeps all-zeros legal and all-ones as the unreachable lockup
  assign tick_s = (cnt_q == {DIV_W{1'b1}});
  assign fb_s   = ~(lfsr_st_q[9] ^ lfsr_st_q[6]);
  assign hit_s  = tick_s & bus.en & (lfsr_st_q < bus.level);

  assign bus.p      = p_q;
  assign bus.lfsr_q = lfsr_st_q;

  // Prescaler and LFSR next-state
  always_comb begin
    cnt_d     = cnt_q + DIV_W'(1);
    lfsr_st_d = lfsr_st_q;
    if (tick_s) begin
      lfsr_st_d = {lfsr_st_q[LFSR_W-2:0], fb_s};
    end else begin
      lfsr_st_d = lfsr_st_q;
    end
  end

  // Prescaler and LFSR state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= {DIV_W{1'b0}};
      lfsr_st_q <= {LFSR_W{1'b0}};
    end else begin
      cnt_q     <= cnt_d;
      lfsr_st_q <= lfsr_st_d;
    end
  end

  // Press FSM; p is registered alongside the state so it is high only in PRESS
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      p_q     <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (hit_s) begin
            state_q <= PRESS;
            p_q     <= 1'b1;
          end else begin
            state_q <= WAIT;
            p_q     <= 1'b0;
          end
        end
        PRESS: begin
          state_q <= HOLD;
          p_q     <= 1'b0;
        end
        HOLD: begin
          if (tick_s) begin
            state_q <= WAIT;
          end else begin
            state_q <= HOLD;
          end
          p_q <= 1'b0;
        end
        default: begin
          state_q <= WAIT;
          p_q     <= 1'b0;
        end
      endcase
    end
  end

endmodule
